// File: rtl/oric_sdram_bridge.sv
// oric_sdram_bridge: Oric level-strobe RAM accesses to toggle-handshake SDRAM word requests with one pending slot and a one-word read hit cache
module oric_sdram_bridge #(
    parameter int TIMEOUT_CYC = 64,
    parameter bit HIT_EN      = 1'b1
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    output logic [7:0]  ram_q,
    output logic        port_req,
    input  logic        port_ack,
    output logic [14:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    output logic [15:0] port_d,
    input  logic [15:0] port_q,
    output logic        busy,
    output logic        ovf,
    output logic        tmo
);
    localparam int WW = $clog2(TIMEOUT_CYC);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic prev_rd, prev_wr, ack_seen, cur_ad0;
    logic [15:0] prev_ad;
    logic [WW-1:0] wdog;
    logic pend_v, pend_we;
    logic [15:0] pend_ad;
    logic [7:0] pend_d;
    logic hit_v;
    logic [14:0] hit_a;
    logic [15:0] hit_word;
    logic rd, wr, new_wr, new_rd, acc, hit, issue_pend, issue, done, fire, store;
    logic [15:0] iss_ad;
    logic [7:0] iss_d;
    logic iss_we;
    always_comb begin
        rd = ram_cs & ram_oe;
        wr = ram_cs & ram_we;
        new_wr = wr & ~prev_wr;
        new_rd = rd & (~prev_rd | (ram_ad != prev_ad));
        acc = new_wr | new_rd;
        hit = HIT_EN && state == IDLE && !pend_v && !new_wr && new_rd && hit_v && ram_ad[15:1] == hit_a;
        issue_pend = state == IDLE && pend_v;
        issue = issue_pend || (state == IDLE && acc && !hit);
        iss_ad = issue_pend ? pend_ad : ram_ad;
        iss_we = issue_pend ? pend_we : new_wr;
        iss_d = issue_pend ? pend_d : ram_d;
        done = state == WAIT && port_ack != ack_seen;
        fire = state == WAIT && !done && wdog == '0;
        store = acc && (state == WAIT || issue_pend);
        state_nx = issue ? WAIT : (done || fire) ? IDLE : state;
    end
    assign busy = state == WAIT || pend_v;
    always_ff @(posedge clk_sys) begin
        if (!res_n) begin
            state <= IDLE;
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
            prev_ad <= '0;
            ack_seen <= port_ack;
            cur_ad0 <= 1'b0;
            wdog <= '0;
            port_req <= 1'b0;
            port_we <= 1'b0;
            port_a <= '0;
            port_ds <= 2'b11;
            port_d <= '0;
            ram_q <= '0;
            ovf <= 1'b0;
            tmo <= 1'b0;
            pend_v <= 1'b0;
            pend_we <= 1'b0;
            pend_ad <= '0;
            pend_d <= '0;
            hit_v <= 1'b0;
            hit_a <= '0;
            hit_word <= '0;
        end else begin
            state <= state_nx;
            prev_rd <= rd;
            prev_wr <= wr;
            prev_ad <= ram_ad;
            if (state == IDLE) ack_seen <= port_ack;
            if (state == WAIT && wdog != '0) wdog <= wdog - 1'b1;
            if (issue) begin
                port_a <= iss_ad[15:1];
                port_ds <= iss_we ? {iss_ad[0], ~iss_ad[0]} : 2'b11;
                port_we <= iss_we;
                port_d <= {iss_d, iss_d};
                port_req <= ~port_req;
                cur_ad0 <= iss_ad[0];
                wdog <= WW'(TIMEOUT_CYC - 1);
                // keep the cached word coherent with writes that reach SDRAM
                if (iss_we && iss_ad[15:1] == hit_a) begin
                    if (iss_ad[0]) hit_word[15:8] <= iss_d;
                    else hit_word[7:0] <= iss_d;
                end
            end
            if (hit) ram_q <= ram_ad[0] ? hit_word[15:8] : hit_word[7:0];
            if (done) begin
                ack_seen <= port_ack;
                if (!port_we) begin
                    ram_q <= cur_ad0 ? port_q[15:8] : port_q[7:0];
                    hit_a <= port_a;
                    hit_word <= port_q;
                    hit_v <= 1'b1;
                end
            end
            if (fire) begin
                tmo <= 1'b1;
                ack_seen <= port_req;
            end
            if (issue_pend) pend_v <= 1'b0;
            if (store) begin
                if (pend_v && !issue_pend) ovf <= 1'b1;
                if (!(pend_v && !issue_pend) || new_wr || !pend_we) begin
                    pend_v <= 1'b1;
                    pend_we <= new_wr;
                    pend_ad <= ram_ad;
                    pend_d <= ram_d;
                end
            end
        end
    end
endmodule
